// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command FIFO, credit-gated ALU issue, in-order tagged response FIFO
module alu_cmd_issuer #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int LATENCY   = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [7:0]       i_cmd_a,
  input  logic [7:0]       i_cmd_b,
  input  logic [2:0]       i_cmd_opcode,
  input  logic             i_cmd_signed,
  input  logic [TAG_W-1:0] i_cmd_tag,
  output logic [7:0]       o_alu_a,
  output logic [7:0]       o_alu_b,
  output logic [2:0]       o_alu_opcode,
  output logic             o_alu_signed_op,
  input  logic [7:0]       i_alu_result,
  input  logic [3:0]       i_alu_flags,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [7:0]       o_rsp_result,
  output logic [3:0]       o_rsp_flags,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_busy
);
  localparam int CPW   = $clog2(CMD_DEPTH);
  localparam int RPW   = $clog2(RSP_DEPTH);
  localparam int IW    = $clog2(LATENCY + 1);
  localparam int SW    = $clog2(RSP_DEPTH + LATENCY + 1);
  localparam int CMD_W = 20 + TAG_W;
  localparam int RSP_W = 12 + TAG_W;

  logic [CMD_W-1:0] r_cmd_mem [CMD_DEPTH];
  logic [CPW:0]     r_cmd_wr, r_cmd_rd;
  logic [RSP_W-1:0] r_rsp_mem [RSP_DEPTH];
  logic [RPW:0]     r_rsp_wr, r_rsp_rd;
  logic [LATENCY-1:0] r_pipe_vld;
  logic [TAG_W-1:0] r_pipe_tag [LATENCY];
  logic [IW-1:0]    r_inflight;

  logic             w_cmd_empty, w_cmd_full, w_cmd_push, w_issue;
  logic             w_rsp_empty, w_rsp_pop, w_capture;
  logic [RPW:0]     w_rsp_count;
  logic [SW-1:0]    w_credits_used;
  logic [CMD_W-1:0] w_cmd_head;
  logic [RSP_W-1:0] w_rsp_head;

  assign w_cmd_empty = (r_cmd_wr == r_cmd_rd);
  assign w_cmd_full  = (r_cmd_wr[CPW] != r_cmd_rd[CPW]) &&
                       (r_cmd_wr[CPW-1:0] == r_cmd_rd[CPW-1:0]);
  assign w_cmd_push  = i_cmd_valid && !w_cmd_full;
  assign w_cmd_head  = r_cmd_mem[r_cmd_rd[CPW-1:0]];

  assign w_rsp_empty = (r_rsp_wr == r_rsp_rd);
  assign w_rsp_count = r_rsp_wr - r_rsp_rd;
  assign w_rsp_pop   = !w_rsp_empty && i_rsp_ready;
  assign w_rsp_head  = r_rsp_mem[r_rsp_rd[RPW-1:0]];
  assign w_capture   = r_pipe_vld[LATENCY-1];

  // A response slot is reserved for every command in flight; pops free credit only next cycle.
  assign w_credits_used = SW'(r_inflight) + SW'(w_rsp_count);
  assign w_issue        = !w_cmd_empty && (w_credits_used < SW'(RSP_DEPTH));

  assign o_cmd_ready  = !w_cmd_full;
  assign o_rsp_valid  = !w_rsp_empty;
  assign o_rsp_result = o_rsp_valid ? w_rsp_head[RSP_W-1 -: 8] : 8'h00;
  assign o_rsp_flags  = o_rsp_valid ? w_rsp_head[TAG_W+3 -: 4] : 4'h0;
  assign o_rsp_tag    = o_rsp_valid ? w_rsp_head[TAG_W-1:0] : '0;
  assign o_busy       = !w_cmd_empty || (r_inflight != '0) || o_rsp_valid;

  always_ff @(posedge clk) begin
    if (w_cmd_push)
      r_cmd_mem[r_cmd_wr[CPW-1:0]] <= {i_cmd_a, i_cmd_b, i_cmd_opcode, i_cmd_signed, i_cmd_tag};
    if (w_capture)
      r_rsp_mem[r_rsp_wr[RPW-1:0]] <= {i_alu_result, i_alu_flags, r_pipe_tag[LATENCY-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_wr        <= '0;
      r_cmd_rd        <= '0;
      r_rsp_wr        <= '0;
      r_rsp_rd        <= '0;
      r_inflight      <= '0;
      o_alu_a         <= 8'h00;
      o_alu_b         <= 8'h00;
      o_alu_opcode    <= 3'd0;
      o_alu_signed_op <= 1'b0;
    end else begin
      if (w_cmd_push) r_cmd_wr <= r_cmd_wr + (CPW+1)'(1);
      if (w_issue)    r_cmd_rd <= r_cmd_rd + (CPW+1)'(1);
      if (w_capture)  r_rsp_wr <= r_rsp_wr + (RPW+1)'(1);
      if (w_rsp_pop)  r_rsp_rd <= r_rsp_rd + (RPW+1)'(1);
      case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_issue) begin
        o_alu_a         <= w_cmd_head[CMD_W-1 -: 8];
        o_alu_b         <= w_cmd_head[CMD_W-9 -: 8];
        o_alu_opcode    <= w_cmd_head[TAG_W+3 -: 3];
        o_alu_signed_op <= w_cmd_head[TAG_W];
      end
    end
  end

  // Tag pipe mirrors the ALU latency so each captured result pairs with its own tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_tag[0] <= w_cmd_head[TAG_W-1:0];
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_capture) assert (w_rsp_count != (RPW+1)'(RSP_DEPTH));
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - randomized and directed bench for alu_cmd_issuer with queue-based model
module tb_alu_cmd_issuer;
  localparam int CMD_DEPTH = 4;
  localparam int RSP_DEPTH = 4;
  localparam int LATENCY   = 2;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       s;
    logic [3:0] tag;
  } cmd_t;
  typedef struct {
    cmd_t c;
    int   due;
  } inf_t;
  typedef struct packed {
    logic [11:0] rf;
    logic [3:0]  tag;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_opcode = '0;
  logic cmd_signed = 1'b0;
  logic [3:0] cmd_tag = '0;
  logic cmd_ready, rsp_valid, busy, alu_signed_op;
  logic [7:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] alu_opcode;
  logic [3:0] alu_flags, rsp_flags, rsp_tag;
  logic [11:0] alu_q = '0;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit accepted;
  cmd_t cmdq[$], stim_q[$], last_alu;
  inf_t infq[$];
  rsp_t rspq[$];
  logic [3:0] got_q[$];
  int got_cyc[$];

  alu_cmd_issuer dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_opcode(cmd_opcode),
    .i_cmd_signed(cmd_signed), .i_cmd_tag(cmd_tag),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_opcode(alu_opcode),
    .o_alu_signed_op(alu_signed_op),
    .i_alu_result(alu_result), .i_alu_flags(alu_flags),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_flags(rsp_flags), .o_rsp_tag(rsp_tag),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Returns {result, carry, overflow, zero, negative}.
  function automatic logic [11:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [2:0] op, logic s);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; w = '0; r = '0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                  v = s && (a[7] == b[7]) && (r[7] != a[7]); end
      3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                  v = s && (a[7] != b[7]) && (r[7] != a[7]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: begin r = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    return {r, c, v, (r == 8'h00), r[7]};
  endfunction

  // External ALU stand-in: one register stage, so results are sampled LATENCY=2 edges after alu_* update.
  always @(posedge clk) alu_q <= alu_fn(alu_a, alu_b, alu_opcode, alu_signed_op);
  assign alu_result = alu_q[11:4];
  assign alu_flags  = alu_q[3:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    cmd_t c;
    rsp_t r;
    bit issue, push, pop, cap;
    int e;
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 32'(cmdq.size() < CMD_DEPTH));
    chk("rsp_valid", 32'(rsp_valid), 32'(rspq.size() != 0));
    if (rspq.size() != 0)
      chk("rsp_head", 32'({rsp_result, rsp_flags, rsp_tag}), 32'(rspq[0]));
    chk("busy", 32'(busy), 32'(cmdq.size() != 0 || infq.size() != 0 || rspq.size() != 0));
    chk("alu_out", 32'({alu_a, alu_b, alu_opcode, alu_signed_op}),
        32'({last_alu.a, last_alu.b, last_alu.op, last_alu.s}));
    if (rsp_valid && rsp_ready) begin
      got_q.push_back(rsp_tag);
      got_cyc.push_back(cyc);
    end
    e     = cyc + 1;
    issue = cmdq.size() != 0 && (infq.size() + rspq.size()) < RSP_DEPTH;
    push  = cmd_valid && cmdq.size() < CMD_DEPTH;
    pop   = rspq.size() != 0 && rsp_ready;
    cap   = infq.size() != 0 && infq[0].due == e;
    if (pop) void'(rspq.pop_front());
    if (cap) begin
      c = infq[0].c;
      r.rf  = alu_fn(c.a, c.b, c.op, c.s);
      r.tag = c.tag;
      rspq.push_back(r);
      void'(infq.pop_front());
    end
    if (issue) begin
      c = cmdq.pop_front();
      last_alu = c;
      infq.push_back('{c: c, due: e + LATENCY});
    end
    if (push) cmdq.push_back('{a: cmd_a, b: cmd_b, op: cmd_opcode, s: cmd_signed, tag: cmd_tag});
    accepted = push;
    cyc = e;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_t c);
    cmd_a = c.a; cmd_b = c.b; cmd_opcode = c.op; cmd_signed = c.s; cmd_tag = c.tag;
  endtask

  task automatic run_cmds(input int budget, output int n_acc);
    n_acc = 0;
    for (int k = 0; k < budget && stim_q.size() != 0; k++) begin
      drive(stim_q[0]);
      cmd_valid = 1'b1;
      tick();
      if (accepted) begin
        void'(stim_q.pop_front());
        n_acc++;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    k = 0;
    while (k < budget && (cmdq.size() != 0 || infq.size() != 0 || rspq.size() != 0)) begin
      tick();
      k++;
    end
    chk("drain_done", 32'(cmdq.size() + infq.size() + rspq.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_state_checks(input string nm);
    chk({nm, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_rsp_fields"}, 32'({rsp_result, rsp_flags, rsp_tag}), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_alu"}, 32'({alu_a, alu_b, alu_opcode, alu_signed_op}), 32'd0);
  endtask

  initial begin
    int n1, n2;
    cmd_t c;
    last_alu = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    reset_state_checks("reset");

    chk("fn_sadd", 32'(alu_fn(8'h7F, 8'h01, 3'd0, 1'b1)), 32'h805);
    chk("fn_uadd", 32'(alu_fn(8'hFF, 8'h01, 3'd0, 1'b0)), 32'h00A);
    chk("fn_usub", 32'(alu_fn(8'h10, 8'h20, 3'd1, 1'b0)), 32'hF09);
    chk("fn_shl",  32'(alu_fn(8'h81, 8'h00, 3'd6, 1'b0)), 32'h028);
    chk("fn_shr",  32'(alu_fn(8'h81, 8'h00, 3'd7, 1'b0)), 32'h408);
    chk("fn_not",  32'(alu_fn(8'h00, 8'h00, 3'd5, 1'b0)), 32'hFF1);

    // Signed overflow case with first-response latency.
    rsp_ready = 1'b1;
    stim_q.push_back('{a: 8'h7F, b: 8'h01, op: 3'd0, s: 1'b1, tag: 4'd3});
    run_cmds(5, n1);
    chk("t1_accept", 32'(n1), 32'd1);
    tick(); tick();
    chk("t1_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp", 32'({rsp_result, rsp_flags, rsp_tag}), 32'h80_5_3);
    drain(20);

    // Flag corner cases routed through the DUT.
    stim_q.push_back('{a: 8'hFF, b: 8'h01, op: 3'd0, s: 1'b0, tag: 4'd1});
    stim_q.push_back('{a: 8'h10, b: 8'h20, op: 3'd1, s: 1'b0, tag: 4'd2});
    stim_q.push_back('{a: 8'h81, b: 8'h00, op: 3'd6, s: 1'b0, tag: 4'd4});
    stim_q.push_back('{a: 8'h81, b: 8'h00, op: 3'd7, s: 1'b0, tag: 4'd5});
    stim_q.push_back('{a: 8'h00, b: 8'h00, op: 3'd5, s: 1'b0, tag: 4'd6});
    run_cmds(30, n1);
    drain(30);

    // Back-to-back stream must drain without bubbles.
    got_q.delete(); got_cyc.delete();
    for (int i = 0; i < 8; i++)
      stim_q.push_back('{a: 8'($urandom), b: 8'($urandom), op: 3'(i), s: 1'(i), tag: 4'(i)});
    run_cmds(20, n1);
    chk("t3_accept", 32'(n1), 32'd8);
    drain(30);
    chk("t3_count", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("t3_order", 32'(got_q[i]), 32'(i));
    if (got_cyc.size() == 8) chk("t3_no_bubble", 32'(got_cyc[7] - got_cyc[0]), 32'd7);

    // Credit back-pressure: only RSP_DEPTH issue while responses are held.
    got_q.delete(); got_cyc.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      stim_q.push_back('{a: 8'($urandom), b: 8'($urandom), op: 3'($urandom), s: 1'($urandom), tag: 4'(i)});
    run_cmds(15, n1);
    chk("t4_stall_accept", 32'(n1), 32'd8);
    chk("t4_cmd_ready", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    run_cmds(40, n2);
    chk("t4_total_accept", 32'(n1 + n2), 32'd10);
    drain(40);
    chk("t4_count", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) chk("t4_order", 32'(got_q[i]), 32'(i));

    // Asynchronous reset with work queued and in flight.
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      stim_q.push_back('{a: 8'($urandom), b: 8'($urandom), op: 3'($urandom), s: 1'b0, tag: 4'(i)});
    run_cmds(10, n1);
    #3 rst = 1'b1;
    #1;
    reset_state_checks("midrst");
    cmdq.delete(); infq.delete(); rspq.delete(); last_alu = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = cyc + 1;
    reset_state_checks("postrst");
    tick(); tick();
    stim_q.push_back('{a: 8'h12, b: 8'h34, op: 3'd0, s: 1'b0, tag: 4'd9});
    run_cmds(5, n1);
    tick(); tick(); tick();
    chk("t5_rsp", 32'({rsp_valid, rsp_result, rsp_flags, rsp_tag}), 32'h1_46_0_9);
    drain(20);

    // Random traffic with varying response back-pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        if (!cmd_valid || accepted) begin
          cmd_valid = ($urandom_range(0, 3) != 0);
          c = '{a: 8'($urandom), b: 8'($urandom), op: 3'($urandom), s: 1'($urandom), tag: 4'($urandom)};
          drive(c);
        end
        rsp_ready = ($urandom_range(0, 9) < (ph * 3 + 1));
        tick();
      end
    end
    drain(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
